// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter: FSM state encodings,
//   requester port ids, and the byte-enable width derived from the data width.
//   Configuration macro used by the design: DMEM_ARB_RMW_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // One byte enable per 8-bit lane of the data word.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter2
//   Combinational two-way round-robin arbiter. No state.
//   Ports:
//     req[1:0]  request lines (bit n = port n)
//     last      id of the port granted most recently
//     gnt[1:0]  one-hot grant (all zero when no request)
//     win_id    id of the winning port (PORT0 when nobody requests)
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       win_id
);

  always_comb begin
    win_id = PORT0;
    if (req == 2'b11) begin
      // Tie: the port that was not served last goes first.
      win_id = ~last;
    end else if (req[1]) begin
      win_id = PORT1;
    end
    gnt = 2'b00;
    if (|req) begin
      gnt[win_id] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port, combinational-read data memory between two
//   requesters (port 0 = core load/store, port 1 = debug/DMA) with
//   round-robin arbitration. Optional byte-enabled stores are done as a
//   read-modify-write (ACCESS reads, MERGE writes the merged word).
//   Macro: DMEM_ARB_RMW_EN -- when undefined, be is ignored and every store
//   is a single full-word write.
//   Ports:
//     clk, rst                      clock, async active-high reset
//     mN_req/we/addr/wdata/be       request N (held until mN_gnt)
//     mN_gnt                        combinational accept, IDLE only
//     mN_rvalid/mN_rdata            load response (one-cycle pulse)
//     mem_addr/mem_dataW/mem_memRW  drive data_mem
//     mem_dataR                     data_mem read data
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int BE_W  = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [BE_W-1:0]   m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [BE_W-1:0]   m1_be,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataW,
  output logic              mem_memRW,
  input  logic [DATA_W-1:0] mem_dataR
);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic              id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [1:0]        arb_gnt;
  logic              win_id;
  logic              unused_bits;

  rr_arbiter2 u_rr (
    .req    ({m1_req, m0_req}),
    .last   (last_q),
    .gnt    (arb_gnt),
    .win_id (win_id)
  );

  // Grants only in IDLE, and never while reset is asserted.
  assign m0_gnt = arb_gnt[0] & (state_q == ST_IDLE) & ~rst;
  assign m1_gnt = arb_gnt[1] & (state_q == ST_IDLE) & ~rst;

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

`ifdef DMEM_ARB_RMW_EN
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] merged_q, merged_d;
  logic [DATA_W-1:0] merge_word;

  // Per-lane merge of new store bytes over the current memory word.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign merge_word[8*gi +: 8] = be_q[gi] ? wdata_q[8*gi +: 8]
                                            : mem_dataR[8*gi +: 8];
  end

  assign unused_bits = ^addr_q[1:0];
`else
  assign unused_bits = ^{addr_q[1:0], m0_be, m1_be};
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    we_d      = we_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    mem_addr  = '0;
    mem_dataW = '0;
    mem_memRW = 1'b0;
`ifdef DMEM_ARB_RMW_EN
    be_d      = be_q;
    merged_d  = merged_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          we_d    = win_id ? m1_we    : m0_we;
          addr_d  = win_id ? m1_addr  : m0_addr;
          wdata_d = win_id ? m1_wdata : m0_wdata;
          id_d    = win_id;
          last_d  = win_id;
`ifdef DMEM_ARB_RMW_EN
          be_d    = win_id ? m1_be : m0_be;
`endif
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_dataW = wdata_q;
        state_d   = ST_IDLE;
        if (!we_q) begin
          if (id_q == PORT1) begin
            rdata1_d  = mem_dataR;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_dataR;
            rvalid0_d = 1'b1;
          end
        end else begin
`ifdef DMEM_ARB_RMW_EN
          if (&be_q) begin
            mem_memRW = 1'b1;
          end else if (|be_q) begin
            merged_d = merge_word;
            state_d  = ST_MERGE;
          end
`else
          mem_memRW = 1'b1;
`endif
        end
      end
`ifdef DMEM_ARB_RMW_EN
      ST_MERGE: begin
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_dataW = merged_q;
        mem_memRW = 1'b1;
        state_d   = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= PORT1;
      we_q      <= 1'b0;
      id_q      <= PORT0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifdef DMEM_ARB_RMW_EN
      be_q      <= '0;
      merged_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      we_q      <= we_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
`ifdef DMEM_ARB_RMW_EN
      be_q      <= be_d;
      merged_q  <= merged_d;
`endif
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port `data_mem` (word-wide, combinational read on `dataR`, write on posedge `clk` when `memRW`=1). It shares the memory between the core load/store path (port 0) and a secondary requester such as a debug/DMA engine (port 1), using round-robin arbitration. It also performs byte-enabled stores as read-modify-write sequences. It sits between the RV32 pipeline's memory stage and `data_mem`, and drives `data_mem`'s `addr`, `dataW` and `memRW` directly.

## Interface
Parameters:
- `ADDR_W`, 32, request and memory address width.
- `DATA_W`, 32, data width; the byte-enable width is `DATA_W/8`.

Ports (the same set is repeated for `m1_*`):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req`  in  1  request valid; must be held with its payload until `m0_gnt`.
- `m0_we`  in  1  1 = store, 0 = load.
- `m0_addr`  in  ADDR_W  byte address.
- `m0_wdata`  in  DATA_W  store data, lane-aligned.
- `m0_be`  in  DATA_W/8  byte enables, used for stores only.
- `m0_gnt`  out  1  combinational; request accepted this cycle.
- `m0_rvalid`  out  1  one-cycle pulse; `m0_rdata` is valid.
- `m0_rdata`  out  DATA_W  load data, full word.
- `mem_addr`  out  ADDR_W  to `data_mem.addr`.
- `mem_dataW`  out  DATA_W  to `data_mem.dataW`.
- `mem_memRW`  out  1  to `data_mem.memRW`.
- `mem_dataR`  in  DATA_W  from `data_mem.dataR`.

## Operation
- States: IDLE, ACCESS, MERGE.
- IDLE
  - If any `req` is high, pick a winner and assert its `gnt` combinationally.
  - Latch `we`, `addr`, `wdata`, `be` and the winner's port id, then go to ACCESS.
- Arbitration
  - Round-robin on a `last` register. The port not granted most recently wins a tie.
  - `last` resets to 1, so port 0 wins the first tie.
  - A lone requester always wins.
- ACCESS
  - `mem_addr` = latched address with bits [1:0] forced to 0.
  - Load: `mem_memRW`=0. Register `mem_dataR` into the winner's `rdata`, pulse its `rvalid` in the next cycle, go to IDLE.
  - Store with `be`=all ones: `mem_memRW`=1, `mem_dataW`=`wdata`, go to IDLE.
  - Store with a partial `be`: `mem_memRW`=0. Latch the merged word (per byte: `be` ? `wdata` : `mem_dataR`), go to MERGE.
  - Store with `be`=0: no write, `mem_memRW`=0, go to IDLE.
- MERGE: `mem_memRW`=1, `mem_dataW`=merged word, go to IDLE.
- IDLE drive values: `mem_memRW`=0, `mem_addr`=0, `mem_dataW`=0.
- Stores produce no `rvalid`.
- The `rdata` of the non-winning port holds its previous value.
- `gnt` is never asserted outside IDLE. A request that arrives mid-transaction waits.

## Timing
- Load: `gnt` in cycle T, memory read in T+1, `rvalid`/`rdata` in T+2. Next grant is possible in T+2.
- Full-word store: `gnt` in T, written at the posedge ending T+1.
- Partial store: `gnt` in T, read in T+1, written at the posedge ending T+2. Next grant is possible in T+3.
- Back-to-back transactions from both ports alternate with zero idle cycles between them, beyond the required IDLE cycle.
- Reset (at any time, including mid-MERGE)
  - State goes to IDLE and `last` goes to 1.
  - `mem_memRW`, all `gnt`, all `rvalid` and all `rdata` go to 0 immediately.
  - An interrupted partial store leaves memory unmodified.
  - No `rvalid` is issued for a transaction interrupted by reset.

## Configuration
- `DMEM_ARB_RMW_EN` defined: byte-enabled stores use the ACCESS→MERGE read-modify-write sequence described above.
- Undefined:
  - The MERGE state and the merge datapath are removed, and `be` is ignored.
  - Every store is a single full-word write in ACCESS.
  - `be`=0 still writes the full word.

## Structure
- Shared package `dmem_arb_pkg` holds:
  - the state encodings (IDLE=2'd0, ACCESS=2'd1, MERGE=2'd2);
  - the port-id constants;
  - the `be` width derivation.
- One sub-module, `rr_arbiter2`, computes the two-way round-robin winner from `req[1:0]` and `last`. It is combinational and owns no state.

## Test plan
- Reset, then a port 0 load from 0x8 with memory preloaded to 1234 → `m0_gnt` in T, `m0_rvalid`=1 with `m0_rdata`=1234 in T+2; `m1_rvalid` stays 0.
- Simultaneous `m0_req`/`m1_req` loads held for 6 cycles → grant order 0,1,0 with `gnt` edges 2 cycles apart.
- Port 1 full store 0xDEADBEEF to 0x10, then a port 0 load from 0x10 → `rdata`=0xDEADBEEF.
- RMW build, word preloaded 0x11223344, store `be`=4'b0010 `wdata`=0x0000AA00 → memory holds 0x1122AA44 after T+2, and `mem_memRW` was 0 in T+1 and 1 in T+2.
- Same stimulus without the macro → memory holds 0x0000AA00 after T+1.
- Assert `rst` during MERGE → `mem_memRW` drops the same cycle, the word is unchanged, and no `rvalid` is issued.
